// File: rtl/icache_pkg.sv
// Shared types and widths for the direct-mapped instruction cache.
package icache_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = 4;
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Datapath <-> instruction cache fetch port.
interface icache_if
    import icache_pkg::*;
;
    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;

    modport master (
        output imemREN, imemaddr,
        input  ihit, imemload
    );

    modport slave (
        input  imemREN, imemaddr,
        output ihit, imemload
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache with a two-state fill FSM.
//
// state | meaning
// IDLE  | serve hits combinationally; a miss latches missaddr and starts a fill
// FILL  | iREN held high on missaddr until iwait drops, then the frame is written
module icache
    import icache_pkg::*;
(
    input  logic    CLK,
    input  logic    nRST,
    icache_if.slave dcif,
    output logic    iREN,
    output word_t   iaddr,
    input  logic    iwait,
    input  word_t   iload
);

    icache_frame_t           frames [ICACHE_SETS];
    icache_state_t           state;
    word_t                   missaddr;

    word_t                   req_word;
    logic [ICACHE_TAG_W-1:0] req_tag;
    logic [ICACHE_IDX_W-1:0] req_idx;
    logic [ICACHE_TAG_W-1:0] miss_tag;
    logic [ICACHE_IDX_W-1:0] miss_idx;
    logic                    hit;

    // Byte offset is dropped up front so every later field comes from a word address.
    assign req_word = {dcif.imemaddr[31:2], 2'b00};
    assign req_tag  = req_word[31:ICACHE_IDX_W+2];
    assign req_idx  = req_word[ICACHE_IDX_W+1:2];
    assign miss_tag = missaddr[31:ICACHE_IDX_W+2];
    assign miss_idx = missaddr[ICACHE_IDX_W+1:2];

    assign hit = (state == IDLE) && dcif.imemREN &&
                 frames[req_idx].valid && (frames[req_idx].tag == req_tag);

    assign dcif.ihit     = hit;
    assign dcif.imemload = hit ? frames[req_idx].data : '0;
    assign iaddr         = missaddr;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            missaddr <= '0;
            iREN     <= 1'b0;
            for (int i = 0; i < ICACHE_SETS; i++) begin
                frames[i].valid <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (dcif.imemREN && !hit) begin
                        missaddr <= req_word;
                        state    <= FILL;
                        iREN     <= 1'b1;
                    end
                end
                FILL: begin
                    // The fill always completes; imemREN and imemaddr are ignored here.
                    if (!iwait) begin
                        frames[miss_idx] <= '{valid: 1'b1, tag: miss_tag, data: iload};
                        state            <= IDLE;
                        iREN             <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    iREN  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hits, eviction, mid-fill changes, reset mid-fill, idle.
module tb_icache;
    import icache_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    int errors = 0;
    int checks = 0;

    icache_if dcif ();

    icache dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .dcif  (dcif),
        .iREN  (iREN),
        .iaddr (iaddr),
        .iwait (iwait),
        .iload (iload)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven at edge+2 and checked at edge+3.
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic drive(input logic ren, input logic [31:0] addr, input logic wt, input logic [31:0] ld);
        dcif.imemREN  = ren;
        dcif.imemaddr = addr;
        iwait         = wt;
        iload         = ld;
        #1;
    endtask

    initial begin
        nRST = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 32'h0);
        step();
        step();
        #1;
        check("rst_ihit",     {31'b0, dcif.ihit}, 32'd0);
        check("rst_imemload", dcif.imemload,      32'h0);
        check("rst_iren",     {31'b0, iREN},      32'd0);
        check("rst_iaddr",    iaddr,              32'h0);

        // Idle after reset
        nRST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            drive(1'b0, 32'h0000_0004, 1'b1, 32'h0);
            check("idle_ihit",     {31'b0, dcif.ihit}, 32'd0);
            check("idle_iren",     {31'b0, iREN},      32'd0);
            check("idle_imemload", dcif.imemload,      32'h0);
        end

        // Cold miss on 0x4: three busy cycles then data
        step();
        drive(1'b1, 32'h0000_0004, 1'b1, 32'h0);
        check("cold_req_ihit", {31'b0, dcif.ihit}, 32'd0);
        check("cold_req_iren", {31'b0, iREN},      32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1'b1, 32'h0000_0004, 1'b1, 32'h0);
            check("cold_wait_iren",  {31'b0, iREN},      32'd1);
            check("cold_wait_iaddr", iaddr,              32'h0000_0004);
            check("cold_wait_ihit",  {31'b0, dcif.ihit}, 32'd0);
        end
        step();
        drive(1'b1, 32'h0000_0004, 1'b0, 32'h8C01_0000);
        check("cold_done_iren",  {31'b0, iREN},      32'd1);
        check("cold_done_iaddr", iaddr,              32'h0000_0004);
        check("cold_done_ihit",  {31'b0, dcif.ihit}, 32'd0);
        check("cold_done_load",  dcif.imemload,      32'h0);
        step();
        drive(1'b1, 32'h0000_0004, 1'b1, 32'h0);
        check("cold_hit_ihit", {31'b0, dcif.ihit}, 32'd1);
        check("cold_hit_data", dcif.imemload,      32'h8C01_0000);
        check("cold_hit_iren", {31'b0, iREN},      32'd0);

        // Offset bits ignored; hit stays in IDLE
        step();
        drive(1'b1, 32'h0000_0005, 1'b1, 32'h0);
        check("off_hit_ihit", {31'b0, dcif.ihit}, 32'd1);
        check("off_hit_data", dcif.imemload,      32'h8C01_0000);
        check("off_hit_iren", {31'b0, iREN},      32'd0);
        step();
        drive(1'b1, 32'h0000_0004, 1'b1, 32'h0);
        check("re_hit_ihit", {31'b0, dcif.ihit}, 32'd1);
        check("re_hit_data", dcif.imemload,      32'h8C01_0000);

        // Conflict eviction on index 0
        step();
        drive(1'b1, 32'h0000_0000, 1'b1, 32'h0);
        check("ev0_miss", {31'b0, dcif.ihit}, 32'd0);
        step();
        drive(1'b1, 32'h0000_0000, 1'b0, 32'hAAAA_0000);
        check("ev0_iaddr", iaddr, 32'h0000_0000);
        step();
        drive(1'b1, 32'h0000_0000, 1'b1, 32'h0);
        check("ev0_hit",  {31'b0, dcif.ihit}, 32'd1);
        check("ev0_data", dcif.imemload,      32'hAAAA_0000);
        step();
        drive(1'b1, 32'h0000_0040, 1'b1, 32'h0);
        check("ev40_miss", {31'b0, dcif.ihit}, 32'd0);
        step();
        drive(1'b1, 32'h0000_0040, 1'b0, 32'hBBBB_0000);
        check("ev40_iren",  {31'b0, iREN}, 32'd1);
        check("ev40_iaddr", iaddr,         32'h0000_0040);
        step();
        drive(1'b1, 32'h0000_0040, 1'b1, 32'h0);
        check("ev40_hit",  {31'b0, dcif.ihit}, 32'd1);
        check("ev40_data", dcif.imemload,      32'hBBBB_0000);
        step();
        drive(1'b1, 32'h0000_0000, 1'b1, 32'h0);
        check("ev0_again_miss", {31'b0, dcif.ihit}, 32'd0);
        step();
        drive(1'b1, 32'h0000_0000, 1'b0, 32'hAAAA_0000);
        check("ev0_again_iren",  {31'b0, iREN}, 32'd1);
        check("ev0_again_iaddr", iaddr,         32'h0000_0000);

        // Address change and imemREN drop during a fill of 0x10
        step();
        drive(1'b1, 32'h0000_0010, 1'b1, 32'h0);
        check("mid_req_miss", {31'b0, dcif.ihit}, 32'd0);
        step();
        drive(1'b0, 32'h0000_0020, 1'b1, 32'h0);
        check("mid_f1_iren",  {31'b0, iREN},      32'd1);
        check("mid_f1_iaddr", iaddr,              32'h0000_0010);
        check("mid_f1_ihit",  {31'b0, dcif.ihit}, 32'd0);
        step();
        drive(1'b1, 32'h0000_0020, 1'b1, 32'h0);
        check("mid_f2_iren",  {31'b0, iREN}, 32'd1);
        check("mid_f2_iaddr", iaddr,         32'h0000_0010);
        step();
        drive(1'b1, 32'h0000_0020, 1'b0, 32'h1111_0000);
        check("mid_f3_iaddr", iaddr, 32'h0000_0010);
        step();
        drive(1'b1, 32'h0000_0020, 1'b1, 32'h0);
        check("mid_20_miss", {31'b0, dcif.ihit}, 32'd0);
        check("mid_20_iren", {31'b0, iREN},      32'd0);
        step();
        drive(1'b1, 32'h0000_0020, 1'b0, 32'h2222_0000);
        check("mid_20_fill_iren",  {31'b0, iREN}, 32'd1);
        check("mid_20_fill_iaddr", iaddr,         32'h0000_0020);
        step();
        drive(1'b1, 32'h0000_0020, 1'b1, 32'h0);
        check("mid_20_hit",  {31'b0, dcif.ihit}, 32'd1);
        check("mid_20_data", dcif.imemload,      32'h2222_0000);
        step();
        drive(1'b1, 32'h0000_0010, 1'b1, 32'h0);
        check("mid_10_hit",  {31'b0, dcif.ihit}, 32'd1);
        check("mid_10_data", dcif.imemload,      32'h1111_0000);

        // Reset asserted in the same cycle the fill data arrives
        step();
        drive(1'b1, 32'h0000_0008, 1'b1, 32'h0);
        check("rstf_req_miss", {31'b0, dcif.ihit}, 32'd0);
        step();
        drive(1'b1, 32'h0000_0008, 1'b0, 32'hDEAD_BEEF);
        check("rstf_fill_iren",  {31'b0, iREN}, 32'd1);
        check("rstf_fill_iaddr", iaddr,         32'h0000_0008);
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        drive(1'b0, 32'h0000_0008, 1'b1, 32'h0);
        check("rstf_after_iren",  {31'b0, iREN},      32'd0);
        check("rstf_after_ihit",  {31'b0, dcif.ihit}, 32'd0);
        check("rstf_after_iaddr", iaddr,              32'h0);
        step();
        drive(1'b1, 32'h0000_0008, 1'b1, 32'h0);
        check("rstf_req_again_miss", {31'b0, dcif.ihit}, 32'd0);
        step();
        drive(1'b1, 32'h0000_0008, 1'b0, 32'h0123_4567);
        check("rstf_refill_iren",  {31'b0, iREN}, 32'd1);
        check("rstf_refill_iaddr", iaddr,         32'h0000_0008);
        step();
        drive(1'b1, 32'h0000_0008, 1'b1, 32'h0);
        check("rstf_refill_hit",  {31'b0, dcif.ihit}, 32'd1);
        check("rstf_refill_data", dcif.imemload,      32'h0123_4567);
        // Reset also cleared the earlier frames
        step();
        drive(1'b1, 32'h0000_0004, 1'b1, 32'h0);
        check("rstf_old_frame_miss", {31'b0, dcif.ihit}, 32'd0);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-word-per-block instruction cache.
- Acts as the cache-side responder to the pipeline's instruction fetch port (imemREN/imemaddr in, ihit/imemload out).
- Acts as the initiator toward the memory controller's instruction port.
- Hits are answered in the same cycle. Misses are filled from memory through a two-state FSM, then re-served as hits.

Parameters:
- SETS, 16, number of cache frames; power of two.
- IDX_W, 4, index width = log2(SETS).
- TAG_W, 26, tag width = 32 - IDX_W - 2.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  synchronous active-low reset, sampled on rising CLK.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  datapath fetch byte address; bits [1:0] ignored.
- ihit  output  1  requested word valid on imemload this cycle.
- imemload  output  32  instruction word returned to datapath.
- iREN  output  1  read request to memory controller.
- iaddr  output  32  word-aligned fill address to memory controller.
- iwait  input  1  memory busy; iload valid in the cycle iwait is low while iREN is high.
- iload  input  32  fill data from memory controller.

Behaviour:
- Clock and reset: one clock, CLK. Reset is nRST, synchronous and active-low. All state changes on rising CLK.
- Address split: tag = imemaddr[31:IDX_W+2], index = imemaddr[IDX_W+1:2], offset = [1:0] (ignored).
- Frame contents: valid, tag[TAG_W], data[32].
- Reset (nRST low at an edge):
  - All valid bits cleared; state <= IDLE; latched miss address <= 0.
  - Resulting outputs: ihit=0, imemload=0, iREN=0, iaddr=0.
  - Tag/data contents need not be cleared.
- FSM states: IDLE, FILL.
- IDLE:
  - hit = imemREN && frame[index].valid && frame[index].tag == tag.
  - On hit: ihit=1 combinationally; imemload = frame[index].data; state stays IDLE.
  - On imemREN && !hit: latch {imemaddr[31:2],2'b00} into missaddr; next state FILL; ihit=0.
  - On imemREN=0: ihit=0, imemload=0, no state change.
  - iREN=0 in IDLE.
- FILL:
  - iREN=1; iaddr=missaddr; ihit=0; imemload=0.
  - While iwait=1: stay in FILL.
  - When iwait=0: write frame[missaddr index] <= {1, missaddr tag, iload}; next state IDLE.
- Latency:
  - Hit: 0 cycles (same cycle as request).
  - Miss: 1 cycle to enter FILL, N cycles of iwait, 1 cycle to return to IDLE. The hit is then served in that IDLE cycle if imemaddr is unchanged.
- Mid-fill boundary conditions:
  - A fill, once started, always completes; it is never aborted by imemREN dropping.
  - A change in imemaddr during FILL does not affect the fill; missaddr is used.
  - After returning to IDLE, the current imemaddr is looked up fresh.
- Simultaneous fill and request: ihit is never asserted in the cycle the fill is written. Data becomes visible the following cycle (registered write).
- Conflict eviction: a fill overwrites the frame unconditionally. No dirty state; no writeback.
- Reset mid-fill:
  - Reset takes priority: no frame write even if iwait=0 in that cycle.
  - state <= IDLE; iREN deasserts after that edge.
- imemREN=0 in the datapath's halt state: the cache idles. An in-flight fill still completes.

Decomposition:
- cpu_types_pkg additions:
  - ICACHE_IDX_W, ICACHE_TAG_W constants.
  - icache_frame_t packed struct {valid, tag, data}.
  - icache_state_t enum {IDLE, FILL}.
  - Reuse existing word_t.
- Single module; the frame array is an internal register array, no sub-module.
- Ports are grouped on the cache-side modport of the existing datapath_cache_if plus the memory-side signals.

Test Plan:
- Cold miss:
  - Stimulus: reset; imemREN=1, imemaddr=0x00000004; memory holds iwait=1 for 3 cycles, then iwait=0 with iload=0x8C010000.
  - Required: iREN=1 with iaddr=0x00000004 for 4 cycles; then ihit=1, imemload=0x8C010000 the next cycle.
- Hit after fill: reissue 0x00000004, then 0x00000005 (offset ignored) -> ihit=1 same cycle, iREN=0, imemload=0x8C010000 both times.
- Conflict eviction:
  - Stimulus: fill 0x00000000 (data 0xAAAA0000), then 0x00000040 (index 0, data 0xBBBB0000), then request 0x00000000.
  - Required: second request for 0x00000000 misses; iREN=1, iaddr=0x00000000.
- Address change mid-fill:
  - Stimulus: miss on 0x00000010; during FILL switch imemaddr to 0x00000020 and drop imemREN for a cycle.
  - Required: iaddr stays 0x00000010 until iwait=0; frame 4 is filled; the request for 0x20 then misses and starts a new fill.
- Reset mid-fill:
  - Stimulus: during FILL for 0x00000008, assert nRST=0 in the same cycle iwait=0.
  - Required: after the edge, iREN=0 and ihit=0; a subsequent request for 0x00000008 misses (frame not written).
- Idle: imemREN=0 for 5 cycles after reset -> ihit=0, iREN=0, imemload=0 throughout.
